comparador_1bit_struct: RTL and testbench
=========================================

# comparador_1bit_struct

Registered unsigned magnitude comparator built structurally from 1-bit gate-level cells. With the default width it compares two single bits `a` and `b` and reports exactly one of maior (a>b), menor (a<b) or igual (a==b). It is a leaf block in the datapath; downstream control logic consumes the three one-hot flags one clock after the operands are presented.

## Interface
- `WIDTH`, default 1: operand width in bits; legal range 1..32.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  WIDTH  operand A, unsigned.
- `b`  input  WIDTH  operand B, unsigned.
- `maior`  output  1  registered; 1 when a > b.
- `menor`  output  1  registered; 1 when a < b.
- `igual`  output  1  registered; 1 when a == b.

## Operation
- Comparison is unsigned, evaluated MSB first.
- Per-bit cell logic is gate-level:
  - gt_i = a_i & ~b_i
  - lt_i = ~a_i & b_i
  - eq_i = ~(a_i ^ b_i)
- Ripple from MSB to LSB with cascade signals (gt_in, lt_in, eq_in):
  - gt_out = gt_in | (eq_in & gt_i)
  - lt_out = lt_in | (eq_in & lt_i)
  - eq_out = eq_in & eq_i
- MSB cell cascade inputs are tied to gt=0, lt=0, eq=1.
- The final cascade outputs feed three flip-flops that drive maior, menor and igual.
- Invariant: exactly one of maior, menor and igual is 1 at every clock edge, including during and after reset.
- Reset values: maior=0, menor=0, igual=1.
- X/Z on the inputs is not handled; the inputs are required to be driven.

## Timing
- Latency is 1 cycle. The operands sampled at rising edge N appear on the outputs right after edge N and hold until edge N+1.
- No handshake. A new comparison is taken every cycle.
- `rst`=1 at an edge forces the reset values regardless of `a` and `b`. Reset has priority over the data update.
- At the first edge with `rst`=0, the outputs load the comparison of the operands present at that edge.
- Reset asserted mid-stream discards the in-flight result. No stale result reappears after `rst` is released.
- Asserting `rst` has no effect on the outputs between clock edges.
- Operand changes between edges do not affect the outputs until the next edge. The combinational path from `a`/`b` to the flops is a single ripple of WIDTH cells.

## Structure
- Shared package `comparador_pkg` holds:
  - reset constants RST_MAIOR=0, RST_MENOR=0, RST_IGUAL=1
  - MSB cascade seed constants
- One sub-module, `comparador1bit_celula`:
  - purely combinational, gate primitives only (and/or/not/xnor)
  - ports a, b, gt_in, lt_in, eq_in, gt_out, lt_out, eq_out
- The top level instantiates WIDTH cells via generate, then the output register stage.
- No other state is permitted.

## Test plan
- WIDTH=1, `rst`=1 for 2 cycles with a=1, b=0 -> maior=0, menor=0, igual=1 throughout reset.
- WIDTH=1, release reset, then apply (a,b) = (0,0), (0,1), (1,0), (1,1) on successive cycles -> one cycle later, per pair in order:
  - (0,0) -> maior=0, menor=0, igual=1
  - (0,1) -> maior=0, menor=1, igual=0
  - (1,0) -> maior=1, menor=0, igual=0
  - (1,1) -> maior=0, menor=0, igual=1
- WIDTH=1, toggle `a` and `b` between edges, then restore them before the edge -> outputs unchanged until the edge, then reflect the values sampled at the edge.
- WIDTH=1, a=1, b=0 with `rst` asserted for one cycle mid-stream -> result after that edge is igual=1; the next edge with `rst`=0 gives maior=1.
- WIDTH=4:
  - a=4'b1000, b=4'b0111 -> maior=1
  - a=4'b0101, b=4'b0110 -> menor=1
  - a=b=4'b1111 -> igual=1
  - each with 1-cycle latency
- Every cycle, a bench assertion checks that maior+menor+igual equals 1 and that each result matches the a>b / a<b / a==b reference from the previous edge.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared constants and types for the structural magnitude comparator.
package comparador_pkg;

    // Output register values while rst is high: "equal" keeps the flags one-hot
    localparam logic RST_MAIOR = 1'b0;
    localparam logic RST_MENOR = 1'b0;
    localparam logic RST_IGUAL = 1'b1;

    // Cascade seed fed into the MSB cell: nothing decided yet, still equal
    localparam logic SEED_GT = 1'b0;
    localparam logic SEED_LT = 1'b0;
    localparam logic SEED_EQ = 1'b1;

    // Registered comparison result
    typedef struct packed {
        logic maior;
        logic menor;
        logic igual;
    } cmp_res_t;

    localparam cmp_res_t RST_RES = '{maior: RST_MAIOR, menor: RST_MENOR, igual: RST_IGUAL};

    // Pack the final cascade outputs into a result
    function automatic cmp_res_t casc_to_res(input logic gt, input logic lt, input logic eq);
        cmp_res_t r;
        r.maior = gt;
        r.menor = lt;
        r.igual = eq;
        return r;
    endfunction

endpackage

// File: rtl/comparador_1bit_struct_celula.sv
// One bit of the rippled magnitude comparator, built from gate primitives.
// A decision already taken by a more significant bit (gt_in/lt_in) wins;
// this bit only decides while everything above it is still equal.
module comparador1bit_celula (
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic lt_in,
    input  logic eq_in,
    output wire  gt_out,
    output wire  lt_out,
    output wire  eq_out
);

    wire na, nb;
    wire gt_i, lt_i, eq_i;
    wire gt_new, lt_new;

    // Local bit relation
    not  u_na (na, a);
    not  u_nb (nb, b);
    and  u_gt (gt_i, a, nb);
    and  u_lt (lt_i, na, b);
    xnor u_eq (eq_i, a, b);

    // Merge with the cascade coming from the more significant bits
    and  u_gt_new (gt_new, eq_in, gt_i);
    and  u_lt_new (lt_new, eq_in, lt_i);
    or   u_gt_out (gt_out, gt_in, gt_new);
    or   u_lt_out (lt_out, lt_in, lt_new);
    and  u_eq_out (eq_out, eq_in, eq_i);

endmodule

// File: rtl/comparador_1bit_struct.sv
// Registered unsigned magnitude comparator: WIDTH gate-level cells rippled
// MSB to LSB, followed by one register stage holding one-hot maior/menor/igual.
module comparador_1bit_struct
    import comparador_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             maior,
    output logic             menor,
    output logic             igual
);

    // Cascade node k sits above bit k-1; node WIDTH is the seed, node 0 the result
    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] lt_c;
    logic [WIDTH:0] eq_c;
    cmp_res_t       res_q;

    assign gt_c[WIDTH] = SEED_GT;
    assign lt_c[WIDTH] = SEED_LT;
    assign eq_c[WIDTH] = SEED_EQ;

    genvar i;
    generate
        for (i = WIDTH - 1; i >= 0; i--) begin : gen_cel
            comparador1bit_celula u_cel (
                .a      (a[i]),
                .b      (b[i]),
                .gt_in  (gt_c[i+1]),
                .lt_in  (lt_c[i+1]),
                .eq_in  (eq_c[i+1]),
                .gt_out (gt_c[i]),
                .lt_out (lt_c[i]),
                .eq_out (eq_c[i])
            );
        end
    endgenerate

    // Capture the ripple result each edge; reset forces the "equal" state
    always_ff @(posedge clk) begin
        if (rst) res_q <= RST_RES;
        else     res_q <= casc_to_res(gt_c[0], lt_c[0], eq_c[0]);
    end

    assign maior = res_q.maior;
    assign menor = res_q.menor;
    assign igual = res_q.igual;

endmodule

// File: tb/tb_comparador_1bit_struct.sv
// Directed bench for comparador_1bit_struct at WIDTH=1 and WIDTH=4.
module tb_comparador_1bit_struct;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       maior1, menor1, igual1;
    logic       maior4, menor4, igual4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparador_1bit_struct #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .maior(maior1), .menor(menor1), .igual(igual1)
    );

    comparador_1bit_struct #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4),
        .maior(maior4), .menor(menor4), .igual(igual4)
    );

    // Reference result sampled at each rising edge
    logic [2:0] ref1, ref4;
    bit         ref_vld = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ref1 = 3'b001;
            ref4 = 3'b001;
        end else begin
            ref1 = {a1 > b1, a1 < b1, a1 == b1};
            ref4 = {a4 > b4, a4 < b4, a4 == b4};
        end
        ref_vld = 1'b1;
    end

    // Per-cycle one-hot and reference check on the falling edge
    always @(negedge clk) begin
        if (ref_vld) begin
            checks++;
            if ((int'(maior1) + int'(menor1) + int'(igual1)) != 1 ||
                {maior1, menor1, igual1} !== ref1) begin
                errors++;
                $display("FAIL cycle_w1 t=%0t got=%b want=%b", $time, {maior1, menor1, igual1}, ref1);
            end
            checks++;
            if ((int'(maior4) + int'(menor4) + int'(igual4)) != 1 ||
                {maior4, menor4, igual4} !== ref4) begin
                errors++;
                $display("FAIL cycle_w4 t=%0t got=%b want=%b", $time, {maior4, menor4, igual4}, ref4);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; a1 = 1'b1; b1 = 1'b0; a4 = 4'hA; b4 = 4'h3;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({maior1, menor1, igual1} !== 3'b001) begin
                errors++;
                $display("FAIL reset_w1 cyc%0d got=%b want=001", k, {maior1, menor1, igual1});
            end
            checks++;
            if ({maior4, menor4, igual4} !== 3'b001) begin
                errors++;
                $display("FAIL reset_w4 cyc%0d got=%b want=001", k, {maior4, menor4, igual4});
            end
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [2:0] exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = 1'b0; a1 = ab[k][1]; b1 = ab[k][0];
            @(posedge clk); #1;
            checks++;
            if ({maior1, menor1, igual1} !== exp[k]) begin
                errors++;
                $display("FAIL truth_%b got=%b want=%b", ab[k], {maior1, menor1, igual1}, exp[k]);
            end
        end
    endtask

    task automatic test_hold_between_edges();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b100) begin
            errors++;
            $display("FAIL hold_load got=%b want=100", {maior1, menor1, igual1});
        end
        // Wiggle operands and pulse rst between edges, then restore
        #1 a1 = 1'b0; b1 = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b100) begin
            errors++;
            $display("FAIL hold_mid got=%b want=100", {maior1, menor1, igual1});
        end
        #1 a1 = 1'b1; b1 = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b100) begin
            errors++;
            $display("FAIL hold_edge got=%b want=100", {maior1, menor1, igual1});
        end
        // Change well before the edge: the edge must pick the new value
        #1 a1 = 1'b0; b1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b010) begin
            errors++;
            $display("FAIL hold_new got=%b want=010", {maior1, menor1, igual1});
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_on got=%b want=001", {maior1, menor1, igual1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({maior1, menor1, igual1} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_off got=%b want=100", {maior1, menor1, igual1});
        end
    endtask

    task automatic test_width4();
        logic [3:0] va  [4] = '{4'b1000, 4'b0101, 4'b1111, 4'b0111};
        logic [3:0] vb  [4] = '{4'b0111, 4'b0110, 4'b1111, 4'b1000};
        logic [2:0] exp [4] = '{3'b100, 3'b010, 3'b001, 3'b010};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a4 = va[k]; b4 = vb[k];
            @(posedge clk); #1;
            checks++;
            if ({maior4, menor4, igual4} !== exp[k]) begin
                errors++;
                $display("FAIL w4_%b_%b got=%b want=%b", va[k], vb[k], {maior4, menor4, igual4}, exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold_between_edges();
        test_mid_reset();
        test_width4();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
